// File: rtl/multicycle_opcode_sequencer.sv
// multicycle_opcode_sequencer
//   Front end of the i281 multicycle datapath. Takes one 16-bit instruction
//   per valid/ready handshake and walks it through its phase path
//   (FETCH/DECODE/EXEC/MEM/WB), emitting one registered micro-op word per
//   active cycle for the downstream opcode stage.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high
//   run          in   1 = advance, 0 = freeze (state held, micro_valid low)
//   instr_valid  in   instr carries a valid instruction word
//   instr        in   {opcode[3:0], rx[1:0], ry[1:0], imm[7:0]}
//   mem_wait     in   (SEQ_MEM_STALL_EN only) hold the FSM in MEM
//   instr_ready  out  sequencer accepts an instruction this cycle
//   micro_op     out  {phase[2:0], opcode[3:0], last}
//   micro_valid  out  micro_op is meaningful this cycle
//   busy         out  an instruction is in flight
//   done         out  one-cycle pulse after the final phase
//
// Configuration
//   SEQ_MEM_STALL_EN  when defined, adds mem_wait so MEM can be stretched.

module multicycle_opcode_sequencer #(
  parameter int OPW    = 4,
  parameter int MICROW = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
`ifdef SEQ_MEM_STALL_EN
  input  logic              mem_wait,
`endif
  output logic              instr_ready,
  output logic [MICROW-1:0] micro_op,
  output logic              micro_valid,
  output logic              busy,
  output logic              done
);

  // Enum values double as the phase code carried in micro_op[7:5].
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } phase_t;

  phase_t         state;
  logic [OPW-1:0] opcode;

  // Final phase of each opcode class; an instruction leaves for IDLE from here.
  function automatic phase_t final_phase(input logic [OPW-1:0] op);
    case (op)
      4'h0:             return DECODE;  // NOOP
      4'hA, 4'hB:       return MEM;     // STORE
      4'hD, 4'hE, 4'hF: return EXEC;    // CMP, JUMP, BRANCH
      default:          return WB;      // ALU/move/shift and LOAD
    endcase
  endfunction

  // Successor phase along the path; only LOAD/STORE visit MEM.
  function automatic phase_t next_phase(input phase_t p, input logic [OPW-1:0] op);
    case (p)
      FETCH:   return DECODE;
      DECODE:  return EXEC;
      EXEC:    return (op[3:2] == 2'b10) ? MEM : WB;
      MEM:     return WB;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [MICROW-1:0] pack_micro(input phase_t p,
                                                    input logic [OPW-1:0] op,
                                                    input logic last);
    return {p, op, last};
  endfunction

  logic [OPW-1:0] opcode_in;
  phase_t         step_phase;
  phase_t         first_final;
  logic           at_final;
  logic           stall;
  logic           unused_operand_bits;

  assign opcode_in   = instr[15 -: OPW];
  assign step_phase  = next_phase(state, opcode);
  assign first_final = final_phase(opcode_in);
  assign at_final    = (state == final_phase(opcode));
  // Register/immediate fields belong to later datapath stages.
  assign unused_operand_bits = ^instr[15-OPW:0];

`ifdef SEQ_MEM_STALL_EN
  assign stall = (state == MEM) && mem_wait;
`else
  assign stall = 1'b0;
`endif

  // Single FSM; all outputs are registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      opcode      <= '0;
      micro_op    <= '0;
      micro_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      instr_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        micro_valid <= 1'b0;
        micro_op    <= '0;
        if (instr_valid && instr_ready) begin
          opcode      <= opcode_in;
          state       <= FETCH;
          micro_op    <= pack_micro(FETCH, opcode_in, first_final == FETCH);
          micro_valid <= 1'b1;
          busy        <= 1'b1;
          instr_ready <= 1'b0;
        end else begin
          busy        <= 1'b0;
          instr_ready <= run;
        end
      end else if (!run) begin
        // Freeze: state, latched opcode and the shown micro-op all hold.
        micro_valid <= 1'b0;
      end else if (stall) begin
        // Re-emit the MEM word unchanged while memory is not ready.
        micro_valid <= 1'b1;
      end else if (at_final) begin
        state       <= IDLE;
        micro_op    <= '0;
        micro_valid <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        instr_ready <= 1'b1;
      end else begin
        state       <= step_phase;
        micro_op    <= pack_micro(step_phase, opcode, step_phase == final_phase(opcode));
        micro_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_opcode_sequencer.sv
// tb_multicycle_opcode_sequencer
//   Scoreboard bench: each accepted instruction pushes its expected micro-op
//   words (built from the opcode's phase path) into a queue; a monitor pops
//   and compares whenever micro_valid is high and tracks busy/done/ready.

module tb_multicycle_opcode_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        instr_valid;
  logic [15:0] instr;
  logic        mem_wait;
  logic        instr_ready;
  logic [7:0]  micro_op;
  logic        micro_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];

  multicycle_opcode_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .instr_valid (instr_valid),
    .instr       (instr),
`ifdef SEQ_MEM_STALL_EN
    .mem_wait    (mem_wait),
`endif
    .instr_ready (instr_ready),
    .micro_op    (micro_op),
    .micro_valid (micro_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected micro-op words from the opcode's phase list.
  function automatic void push_path(input logic [3:0] op);
    int ph[$];
    if (op == 4'h0)                     ph = '{1, 2};
    else if (op >= 4'hD)                ph = '{1, 2, 3};
    else if (op == 4'hA || op == 4'hB)  ph = '{1, 2, 3, 4};
    else if (op == 4'h8 || op == 4'h9)  ph = '{1, 2, 3, 4, 5};
    else                                ph = '{1, 2, 3, 5};
    foreach (ph[i]) sb.push_back({3'(ph[i]), op, (i == ph.size() - 1)});
  endfunction

  // Offer w until accepted; optionally drop run for flen cycles starting
  // gap cycles after the accept.
  task automatic send(input logic [15:0] w, input int gap, input int flen);
    bit got = 0;
    instr = w;
    instr_valid = 1'b1;
    run = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clock);
      if (instr_ready) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_ready expected=ready instr=%0h", w);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clock);
    push_path(w[15:12]);
    #1;
    if (flen > 0) begin
      instr_valid = 1'b0;
      repeat (gap) begin @(posedge clock); #1; end
      run = 1'b0;
      repeat (flen) begin @(posedge clock); #1; end
      run = 1'b1;
    end
  endtask

  // Monitor: model of busy/done/ready/valid plus scoreboard pops.
  initial begin
    logic [7:0] w;
    logic [7:0] held = 8'h00;
    bit busy_m = 0, pend_last = 0, run_p = 0, rst_p = 1, acc_p = 0;
    bit exp_done, exp_ready, exp_valid;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("reset_outputs", {micro_op, micro_valid, busy, done, instr_ready}, 32'h0);
        busy_m = 0; pend_last = 0; held = 8'h00;
      end else begin
        exp_done = 0;
        if (rst_p) begin
          busy_m = 0; pend_last = 0; held = 8'h00;
        end else if (busy_m && run_p && pend_last) begin
          busy_m = 0; pend_last = 0; held = 8'h00; exp_done = 1;
        end else if (!busy_m && acc_p) begin
          busy_m = 1;
        end
        exp_ready = !busy_m && run_p && !rst_p;
        exp_valid = busy_m && run_p && !rst_p;
        chk("busy", busy, busy_m);
        chk("done", done, exp_done);
        chk("instr_ready", instr_ready, exp_ready);
        chk("micro_valid", micro_valid, exp_valid);
        if (micro_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_micro_op actual=%0h expected=none", micro_op);
          end else begin
            w = sb.pop_front();
            chk("micro_op", micro_op, w);
            pend_last = w[0];
            held = w;
          end
        end else begin
          chk("micro_op_idle_or_hold", micro_op, busy_m ? held : 8'h00);
        end
      end
      acc_p = instr_valid && instr_ready;
      run_p = run;
      rst_p = reset;
    end
  end

  initial begin
    reset = 1'b1;
    run = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    mem_wait = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock); #1;

    // LOAD, then NOOP and STORE issued back-to-back.
    send(16'h8123, 0, 0);
    send(16'h0ABC, 0, 0);
    send(16'hA555, 0, 0);
    // ADD with run dropped for 3 cycles after DECODE.
    send(16'h4500, 1, 3);
    // JUMP with the next word already waiting during it.
    send(16'hE012, 0, 0);
    send(16'hD0F0, 0, 0);
    send(16'hF7FF, 2, 2);

    // Reset during EXEC of an ADD.
    send(16'h4321, 0, 0);
    instr_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 chk("async_reset_mid_op", {micro_op, micro_valid, busy, done, instr_ready}, 32'h0);
    sb.delete();
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock); #1;

    // Randomized instructions with random freeze windows.
    for (int k = 0; k < 40; k++) begin
      logic [15:0] w;
      int g, f;
      w = 16'($urandom);
      g = 0;
      f = 0;
      if ($urandom_range(0, 1) == 1) begin
        g = $urandom_range(0, 5);
        f = $urandom_range(1, 4);
      end
      send(w, g, f);
    end

    instr_valid = 1'b0;
    run = 1'b1;
    repeat (12) @(posedge clock);
    #1 chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
